// File: rtl/turn_signal_seq.sv
// rtl/turn_signal_seq.sv - sequential turn-signal / hazard lamp sequencer
// All outputs registered; a request change restarts the sequence from dark.
module turn_signal_seq #(
  parameter int DIV = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       left,
  input  logic       right,
  input  logic       hazard,
  output logic [2:0] l_signal,
  output logic [2:0] r_signal
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT, HAZ} state_t;

  state_t          state, state_nx, req;
  logic [TW-1:0]   tick, tick_nx;
  logic [1:0]      phase, phase_nx;
  logic [2:0]      l_nx, r_nx;

  // Lamp fill pattern from inside out: 000, 001, 011, 111.
  function automatic logic [2:0] ramp(input logic [1:0] p);
    case (p)
      2'd0:    ramp = 3'b000;
      2'd1:    ramp = 3'b001;
      2'd2:    ramp = 3'b011;
      default: ramp = 3'b111;
    endcase
  endfunction

  always_comb begin
    req = IDLE;
    if (hazard || (left && right)) req = HAZ;
    else if (left)                 req = LEFT;
    else if (right)                req = RIGHT;

    state_nx = state;
    tick_nx  = tick;
    phase_nx = phase;
    l_nx     = l_signal;
    r_nx     = r_signal;

    if (req != state) begin
      state_nx = req;
      tick_nx  = '0;
      phase_nx = 2'd0;
      l_nx     = 3'b000;
      r_nx     = 3'b000;
    end else if (state != IDLE) begin
      if (tick == TICK_LAST) begin
        tick_nx  = '0;
        // Hazard only toggles between dark and full; turn modes walk all four phases.
        phase_nx = (state == HAZ) ? {1'b0, ~phase[0]} : phase + 2'd1;
        case (state)
          LEFT: begin
            l_nx = ramp(phase_nx);
            r_nx = 3'b000;
          end
          RIGHT: begin
            l_nx = 3'b000;
            r_nx = ramp(phase_nx);
          end
          HAZ: begin
            l_nx = {3{phase_nx[0]}};
            r_nx = {3{phase_nx[0]}};
          end
          default: begin
            l_nx = 3'b000;
            r_nx = 3'b000;
          end
        endcase
      end else begin
        tick_nx = tick + 1'b1;
      end
    end else begin
      tick_nx  = '0;
      phase_nx = 2'd0;
      l_nx     = 3'b000;
      r_nx     = 3'b000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tick     <= '0;
      phase    <= 2'd0;
      l_signal <= 3'b000;
      r_signal <= 3'b000;
    end else begin
      state    <= state_nx;
      tick     <= tick_nx;
      phase    <= phase_nx;
      l_signal <= l_nx;
      r_signal <= r_nx;
    end
  end

endmodule

// File: tb/tb_turn_signal_seq.sv
// tb/tb_turn_signal_seq.sv - scoreboard bench for turn_signal_seq (DIV=4)
// Expected lamps come from a cycles-since-entry model, queued per driven edge.
module tb_turn_signal_seq;

  localparam int DIV = 4;
  localparam int M_IDLE = 0, M_LEFT = 1, M_RIGHT = 2, M_HAZ = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       left = 1'b0, right = 1'b0, hazard = 1'b0;
  logic [2:0] l_signal, r_signal;

  turn_signal_seq #(.DIV(DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .left     (left),
    .right    (right),
    .hazard   (hazard),
    .l_signal (l_signal),
    .r_signal (r_signal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] l;
    logic [2:0] r;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   mode     = M_IDLE;
  int   since    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, want, $time);
  endtask

  function automatic logic [2:0] fill(input int k);
    fill = 3'((1 << k) - 1);
  endfunction

  // Drive one edge worth of inputs, predict the lamps after that edge, compare.
  task automatic step(input logic l, input logic r, input logic h, input logic rs,
                      input bit idle_chk);
    int   req, k;
    exp_t e, got_e;
    @(negedge clk);
    left = l; right = r; hazard = h; rst = rs;
    req = (h || (l && r)) ? M_HAZ : l ? M_LEFT : r ? M_RIGHT : M_IDLE;
    e = '0;
    if (rs) begin
      mode = M_IDLE; since = 0;
    end else if (req != mode) begin
      mode = req; since = 0;
    end else if (mode != M_IDLE) begin
      since++;
      k = since / DIV;
      if (mode == M_LEFT)  e.l = fill(k % 4);
      if (mode == M_RIGHT) e.r = fill(k % 4);
      if (mode == M_HAZ) begin
        e.l = (k % 2) ? 3'b111 : 3'b000;
        e.r = e.l;
      end
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got_e = sb_q.pop_front();
    check("l_signal", 32'(l_signal), 32'(got_e.l));
    check("r_signal", 32'(r_signal), 32'(got_e.r));
    if (idle_chk) begin
      check("idle_tick",  32'(dut.tick),  32'd0);
      check("idle_phase", 32'(dut.phase), 32'd0);
    end
  endtask

  initial begin
    int hold;
    logic rl, rr, rh;

    repeat (2) step(0, 0, 0, 1, 1'b0);
    check("reset_l", 32'(l_signal), 32'd0);
    check("reset_r", 32'(r_signal), 32'd0);

    repeat (20) step(1, 0, 0, 0, 1'b0);               // full left sweep and wrap
    repeat (14) step(0, 0, 1, 0, 1'b0);               // hazard
    repeat (10) step(1, 1, 0, 0, 1'b0);               // left+right acts as hazard
    repeat (1)  step(0, 0, 0, 0, 1'b0);
    repeat (9)  step(1, 0, 0, 0, 1'b0);               // left reaches 011
    check("left_at_011", 32'(l_signal), 32'b011);
    repeat (10) step(0, 1, 0, 0, 1'b0);               // abort into right
    repeat (13) step(0, 1, 0, 0, 1'b0);
    repeat (1)  step(0, 1, 0, 1, 1'b0);               // reset pulse mid-sequence
    repeat (8)  step(0, 1, 0, 0, 1'b0);
    repeat (20) step(0, 0, 0, 0, 1'b1);               // idle holds counters at zero
    repeat (6)  step(1, 0, 0, 0, 1'b0);
    repeat (1)  step(0, 1, 0, 0, 1'b0);               // one-cycle glitch
    repeat (8)  step(1, 0, 0, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      rl = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      rh = ($urandom_range(0, 3) == 0);
      hold = $urandom_range(1, 14);
      for (int j = 0; j < hold; j++) step(rl, rr, rh, ($urandom_range(0, 40) == 0), 1'b0);
    end

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
